instr_fetch_mem: RTL and testbench
==================================

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 Parameter MEM_BYTES, default 128, SHALL set the byte capacity of the instruction store (legal range 16..65536, multiple of 4).
REQ-002 Parameter LATENCY, default 1, SHALL set the cycles from request acceptance to response valid (legal range 1..4).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 ld_en  input  1  SHALL be the program-load byte write strobe.
REQ-006 ld_addr  input  32  SHALL be the byte address of the load write.
REQ-007 ld_data  input  8  SHALL be the byte written on a load.
REQ-008 req_valid  input  1  SHALL indicate that a fetch request is present.
REQ-009 req_ready  output  1  SHALL indicate that a fetch request can be accepted.
REQ-010 req_addr  input  32  SHALL be the byte address of the fetch.
REQ-011 rsp_valid  output  1  SHALL indicate that a fetch response is present.
REQ-012 rsp_ready  input  1  SHALL indicate that the consumer accepts the response.
REQ-013 rsp_instr  output  32  SHALL carry the fetched instruction word.
REQ-014 rsp_err  output  1  SHALL flag a faulted fetch; it is valid while rsp_valid is high.
REQ-015 err_cnt  output  8  SHALL count faulted fetches, saturating at 255.

Function
REQ-016 Storage SHALL be a byte array of MEM_BYTES entries.
REQ-017 Storage contents SHALL NOT be cleared by rst.
REQ-018 A load SHALL occur on any clk edge with ld_en=1 and ld_addr<MEM_BYTES; an out-of-range ld_addr SHALL be silently ignored.
REQ-019 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-020 req_ready SHALL equal (state==IDLE) && !ld_en; a load always wins over a fetch in the same cycle.
REQ-021 A request SHALL be accepted on a cycle with req_valid && req_ready.
REQ-022 On acceptance, the word SHALL be snapshotted big-endian: {mem[a], mem[a+1], mem[a+2], mem[a+3]}, with mem[a] in bits 31:24.
REQ-023 Loads after acceptance SHALL NOT alter the in-flight response.
REQ-024 A fetch SHALL fault if req_addr[1:0]!=0 or req_addr > MEM_BYTES-4, with the comparison done at full 32-bit width and no wrap-around.
REQ-025 A faulted fetch SHALL return rsp_instr=32'h0000_0000 and rsp_err=1.
REQ-026 Transitions on acceptance: with LATENCY=1, IDLE->RESP; otherwise IDLE->WAIT with the latency counter loaded to LATENCY-1.
REQ-027 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL move WAIT->RESP on the cycle the counter reaches 1.
REQ-028 Timing SHALL be exact: rsp_valid rises exactly LATENCY cycles after the accepting edge.
REQ-029 In RESP, rsp_valid=1, and rsp_instr/rsp_err SHALL be held stable until rsp_ready=1.
REQ-030 On rsp_ready=1 in RESP, the FSM SHALL move RESP->IDLE; req_ready stays low in that cycle, so at most one fetch is outstanding and there is no back-to-back acceptance.
REQ-031 err_cnt SHALL increment by 1 in the cycle a faulted response handshakes (rsp_valid && rsp_ready && rsp_err), and SHALL hold at 255.
REQ-032 rsp_instr SHALL be driven to 0 whenever rsp_valid=0.

Reset
REQ-033 While rst=1, the block SHALL hold: state=IDLE, counter=0, rsp_valid=0, rsp_instr=0, rsp_err=0, err_cnt=0.
REQ-034 Because rsp_valid=0 and state=IDLE under reset, req_ready=0 SHALL hold only when ld_en=1.
REQ-035 Reset asserted in WAIT or RESP SHALL abort the in-flight fetch immediately, with no response emitted after release.
REQ-036 Reset SHALL NOT affect storage, and loads SHALL remain functional during reset.

Verification
REQ-037 Load and fetch: load bytes 0x00,0x11,0x22,0x33 at 0..3 with LATENCY=1, then fetch addr 0 -> rsp_valid one cycle after acceptance, rsp_instr=32'h00112233, rsp_err=0.
REQ-038 Latency and backpressure: with LATENCY=4, fetch addr 4 while rsp_ready=0 for 3 cycles -> rsp_valid rises exactly 4 cycles after acceptance, data is held stable, and req_ready=0 until the cycle after the handshake.
REQ-039 Faults: fetch addr 2, then addr 124 with MEM_BYTES=128, then addr 32'hFFFF_FFFC -> addr 2 faults, addr 124 returns a valid word, addr 32'hFFFF_FFFC faults; err_cnt=2 with rsp_instr=0 on both faults.
REQ-040 Load priority and snapshot: assert ld_en together with req_valid -> no acceptance that cycle; after acceptance, a load to the same address -> the response returns the pre-load word.
REQ-041 Reset mid-flight: pulse rst in WAIT -> rsp_valid stays 0 and storage is intact; a subsequent fetch returns the previously loaded data.
REQ-042 Saturation: issue 260 faulted fetches -> err_cnt=255.

Source files
------------

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: a byte-addressed program store with a load port
// and a single-outstanding fetch port. The response arrives a fixed LATENCY
// cycles after acceptance. Misaligned and out-of-range fetches fault.
module instr_fetch_mem #(
    parameter int unsigned MEM_BYTES = 128,
    parameter int unsigned LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [7:0]  ld_data,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic        rsp_err,
    output logic [7:0]  err_cnt
);

    localparam int unsigned AW       = $clog2(MEM_BYTES);
    localparam logic [31:0] MEM_SIZE = 32'(MEM_BYTES);
    // Highest legal word address; compared at full width so nothing wraps.
    localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);
    localparam logic [2:0]  CNT_INIT = 3'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] instr_q;
    logic        err_q;
    logic [7:0]  err_cnt_q;

    logic [7:0]  mem_q [MEM_BYTES];

    logic          accept;
    logic          fetch_fault;
    logic [31:0]   fetch_word;
    logic [AW-1:0] base;

    // Program store: no reset, so loads keep working while rst is held.
    always_ff @(posedge clk) begin
        if (ld_en && (ld_addr < MEM_SIZE)) begin
            mem_q[ld_addr[AW-1:0]] <= ld_data;
        end
    end

    // A load in the same cycle always blocks acceptance of a fetch.
    assign req_ready = (state_q == IDLE) && !ld_en;
    assign accept    = req_valid && req_ready;

    assign fetch_fault = (req_addr[1:0] != 2'b00) || (req_addr > MAX_ADDR);
    assign base        = {req_addr[AW-1:2], 2'b00};

    // Big-endian word assembly; a faulted fetch returns zero.
    always_comb begin
        fetch_word = '0;
        if (!fetch_fault) begin
            fetch_word = {mem_q[base],
                          mem_q[{req_addr[AW-1:2], 2'b01}],
                          mem_q[{req_addr[AW-1:2], 2'b10}],
                          mem_q[{req_addr[AW-1:2], 2'b11}]};
        end
    end

    // FSM state and latency counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE, with WAIT covering
    // the extra LATENCY-1 cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd1) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Snapshot the word at acceptance so later loads cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            instr_q <= fetch_word;
            err_q   <= fetch_fault;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_instr = rsp_valid ? instr_q : 32'h0000_0000;
    assign rsp_err   = rsp_valid && err_q;

    // Saturating count of faulted responses, bumped on their handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (rsp_valid && rsp_ready && rsp_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench: two instances (LATENCY=1 and LATENCY=4) share clock, reset
// and the load port; each has its own fetch/response handshake.
module tb_instr_fetch_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [7:0]  ld_data;
    logic        req_valid [2];
    logic [31:0] req_addr  [2];
    logic        rsp_ready [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_instr [2];
    logic        rsp_err   [2];
    logic [7:0]  err_cnt   [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_fetch_mem #(.MEM_BYTES(128), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_instr(rsp_instr[0]),
        .rsp_err(rsp_err[0]), .err_cnt(err_cnt[0])
    );

    instr_fetch_mem #(.MEM_BYTES(128), .LATENCY(4)) u_dut_l4 (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_instr(rsp_instr[1]),
        .rsp_err(rsp_err[1]), .err_cnt(err_cnt[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; leaves ld_en low at the next falling edge.
    task automatic load_byte(input logic [31:0] addr, input logic [7:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // Full fetch on instance d: request, latency measurement, optional
    // backpressure (hold cycles), optional overwrite of the fetched byte
    // right after acceptance, then handshake.
    task automatic fetch(input string tag, input int d, input logic [31:0] addr,
                         input logic [31:0] exp_instr, input logic exp_err,
                         input int exp_lat, input int hold, input bit snap_ld);
        int n;
        req_valid[d] = 1'b1;
        req_addr[d]  = addr;
        #1;
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n == 20) chk({tag, ".accept_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        req_valid[d] = 1'b0;
        n = 1;
        if (snap_ld) begin
            ld_en   = 1'b1;
            ld_addr = addr;
            ld_data = 8'hFF;
            @(negedge clk);
            ld_en   = 1'b0;
            n = 2;
        end
        while (!rsp_valid[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, n, exp_lat);
        chk({tag, ".instr"}, rsp_instr[d], exp_instr);
        chk({tag, ".err"}, rsp_err[d], exp_err);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, rsp_valid[d], 1'b1);
            chk({tag, ".hold_instr"}, rsp_instr[d], exp_instr);
            chk({tag, ".hold_req_ready"}, req_ready[d], 1'b0);
        end
        rsp_ready[d] = 1'b1;
        #1;
        chk({tag, ".hs_req_ready"}, req_ready[d], 1'b0);
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        chk({tag, ".post_valid"}, rsp_valid[d], 1'b0);
        chk({tag, ".post_instr"}, rsp_instr[d], 32'h0);
        chk({tag, ".post_req_ready"}, req_ready[d], 1'b1);
    endtask

    initial begin
        rst     = 1'b1;
        ld_en   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_addr[d]  = '0;
            rsp_ready[d] = 1'b0;
        end
        repeat (2) @(negedge clk);

        // Reset state on both instances.
        for (int d = 0; d < 2; d++) begin
            chk("rst.rsp_valid", rsp_valid[d], 1'b0);
            chk("rst.rsp_instr", rsp_instr[d], 32'h0);
            chk("rst.rsp_err", rsp_err[d], 1'b0);
            chk("rst.err_cnt", err_cnt[d], 8'h0);
            chk("rst.req_ready", req_ready[d], 1'b1);
        end

        // Loads under reset still land, and block req_ready.
        ld_en = 1'b1; ld_addr = 32'd0; ld_data = 8'h00;
        #1;
        chk("rst.ld_blocks_ready", req_ready[0], 1'b0);
        @(negedge clk);
        ld_en = 1'b0;
        load_byte(32'd1, 8'h11);
        load_byte(32'd2, 8'h22);
        load_byte(32'd3, 8'h33);
        rst = 1'b0;

        load_byte(32'd4, 8'h44);   load_byte(32'd5, 8'h55);
        load_byte(32'd6, 8'h66);   load_byte(32'd7, 8'h77);
        load_byte(32'd8, 8'h01);   load_byte(32'd9, 8'h02);
        load_byte(32'd10, 8'h03);  load_byte(32'd11, 8'h04);
        load_byte(32'd124, 8'hDE); load_byte(32'd125, 8'hAD);
        load_byte(32'd126, 8'hBE); load_byte(32'd127, 8'hEF);
        // Out-of-range loads that would alias onto bytes 0 and 4 if not dropped.
        load_byte(32'h80, 8'hAA);
        load_byte(32'h84, 8'hBB);

        // Basic load-and-fetch, LATENCY=1.
        fetch("ld_fetch", 0, 32'd0, 32'h00112233, 1'b0, 1, 0, 1'b0);

        // LATENCY=4 with three cycles of backpressure.
        fetch("lat4_bp", 1, 32'd4, 32'h44556677, 1'b0, 4, 3, 1'b0);

        // Faults and the top boundary.
        fetch("mis2", 0, 32'd2, 32'h0, 1'b1, 1, 0, 1'b0);
        fetch("top124", 0, 32'd124, 32'hDEADBEEF, 1'b0, 1, 0, 1'b0);
        fetch("wrap", 0, 32'hFFFF_FFFC, 32'h0, 1'b1, 1, 0, 1'b0);
        chk("fault.err_cnt2", err_cnt[0], 8'd2);
        fetch("oob128", 0, 32'd128, 32'h0, 1'b1, 1, 0, 1'b0);
        chk("fault.err_cnt3", err_cnt[0], 8'd3);

        // Load wins over a simultaneous fetch request.
        ld_en = 1'b1; ld_addr = 32'd8; ld_data = 8'h01;
        req_valid[0] = 1'b1; req_addr[0] = 32'd8;
        #1;
        chk("prio.req_ready", req_ready[0], 1'b0);
        @(negedge clk);
        ld_en = 1'b0;
        req_valid[0] = 1'b0;
        #1;
        chk("prio.no_accept", rsp_valid[0], 1'b0);
        chk("prio.idle", req_ready[0], 1'b1);

        // Snapshot: byte 8 is overwritten with FF right after acceptance.
        fetch("snap", 1, 32'd8, 32'h01020304, 1'b0, 4, 0, 1'b1);
        fetch("post_load", 1, 32'd8, 32'hFF020304, 1'b0, 4, 0, 1'b0);

        // Reset mid-flight while the LATENCY=4 instance is in WAIT.
        @(negedge clk);
        req_valid[1] = 1'b1; req_addr[1] = 32'd0;
        #1;
        chk("midrst.accept_ready", req_ready[1], 1'b1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst.valid_in_rst", rsp_valid[1], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.err_cnt_clr", err_cnt[0], 8'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst.no_rsp", rsp_valid[1], 1'b0);
        end
        fetch("after_rst", 1, 32'd0, 32'h00112233, 1'b0, 4, 0, 1'b0);

        // Saturation of the fault counter.
        for (int i = 0; i < 260; i++) begin
            fetch("sat", 0, 32'd1, 32'h0, 1'b1, 1, 0, 1'b0);
            if (i == 254) chk("sat.at255", err_cnt[0], 8'd255);
        end
        chk("sat.final", err_cnt[0], 8'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
